// File: rtl/basic_latch_pkg.sv
// Shared types and helpers for basic_d_latch.
// Optional build macro: BASIC_D_LATCH_CHG_CNT_EN (enables the change counter).
package basic_latch_pkg;

   localparam int CHG_CNT_W = 16;

   typedef logic [CHG_CNT_W-1:0] chg_cnt_t;

   localparam chg_cnt_t CHG_CNT_MAX = '1;

   // Increment that sticks at all-ones instead of wrapping back to zero.
   function automatic chg_cnt_t sat_inc(input chg_cnt_t val);
      if (val == CHG_CNT_MAX) begin
         return val;
      end
      return val + chg_cnt_t'(1);
   endfunction

endpackage : basic_latch_pkg

// File: rtl/basic_d_latch_core.sv
// Level-sensitive storage element: transparent while st is high, holds while
// st is low, forced to RESET_VAL while rst_n is low. Deliberately a latch, not
// a flop: no clock is involved anywhere in this module.
module latch_core
   import basic_latch_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             rst_n,
   input  logic             st,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;

   // Reset dominates; otherwise pass d through while st is high and keep the
   // last value once st drops (no else branch, so the storage is a latch).
   always_latch begin
      if (!rst_n) begin
         q_q = RESET_VAL;
      end else if (st) begin
         q_q = d;
      end
   end

   assign q = q_q;

endmodule : latch_core

// File: rtl/basic_d_latch.sv
// basic_d_latch: transparent/hold latch core plus a clocked side path that
// gives a synchronous copy of the latch output and a change-detect pulse.
// Optional build macro: BASIC_D_LATCH_CHG_CNT_EN adds chg_cnt, a saturating
// count of q_chg pulses.
module basic_d_latch
   import basic_latch_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             cl,
   input  logic             rst_n,
   input  logic             st,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_sync,
`ifdef BASIC_D_LATCH_CHG_CNT_EN
   output chg_cnt_t         chg_cnt,
`endif
   output logic             q_chg
);

   logic [WIDTH-1:0] q_core;
   logic [WIDTH-1:0] q_sync_q;
   logic [WIDTH-1:0] q_sync_d;
   logic             q_chg_q;
   logic             q_chg_d;

   latch_core #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_core (
      .rst_n (rst_n),
      .st    (st),
      .d     (d),
      .q     (q_core)
   );

   // Next-state for the side path: sample the latch output, flag a difference.
   always_comb begin
      q_sync_d = q_core;
      q_chg_d  = (q_core != q_sync_q);
   end

   // Synchronous copy of q and its one-cycle change pulse.
   always_ff @(posedge cl or negedge rst_n) begin
      if (!rst_n) begin
         q_sync_q <= RESET_VAL;
         q_chg_q  <= 1'b0;
      end else begin
         q_sync_q <= q_sync_d;
         q_chg_q  <= q_chg_d;
      end
   end

`ifdef BASIC_D_LATCH_CHG_CNT_EN
   chg_cnt_t chg_cnt_q;
   chg_cnt_t chg_cnt_d;

   // Count each change pulse, stopping at the top of the range.
   always_comb begin
      chg_cnt_d = chg_cnt_q;
      if (q_chg_q) begin
         chg_cnt_d = sat_inc(chg_cnt_q);
      end
   end

   // Change counter register.
   always_ff @(posedge cl or negedge rst_n) begin
      if (!rst_n) begin
         chg_cnt_q <= '0;
      end else begin
         chg_cnt_q <= chg_cnt_d;
      end
   end

   assign chg_cnt = chg_cnt_q;
`endif

   assign q      = q_core;
   assign q_sync = q_sync_q;
   assign q_chg  = q_chg_q;

endmodule : basic_d_latch

// File: tb/tb_basic_d_latch.sv
// Self-checking bench for basic_d_latch (8-bit instance). Directed steps
// following the test plan, then randomized traffic against a behavioural
// model of the latch and its sampled copy.
module tb_basic_d_latch;

   localparam int         W  = 8;
   localparam logic [7:0] RV = 8'h00;

   logic         cl;
   logic         rst_n;
   logic         st;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic [W-1:0] q_sync;
   logic         q_chg;
`ifdef BASIC_D_LATCH_CHG_CNT_EN
   logic [15:0]  chg_cnt;
`endif

   basic_d_latch #(
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) dut (
      .cl     (cl),
      .rst_n  (rst_n),
      .st     (st),
      .d      (d),
      .q      (q),
      .q_sync (q_sync),
`ifdef BASIC_D_LATCH_CHG_CNT_EN
      .chg_cnt(chg_cnt),
`endif
      .q_chg  (q_chg)
   );

   initial cl = 1'b0;
   always #5 cl = ~cl;

   // Reference model state.
   logic [W-1:0] m_q;
   logic [W-1:0] m_sync;
   logic         m_chg;
   int unsigned  m_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".q"}, 16'(q), 16'(m_q));
      chk({tag, ".q_sync"}, 16'(q_sync), 16'(m_sync));
      chk({tag, ".q_chg"}, 16'(q_chg), 16'(m_chg));
`ifdef BASIC_D_LATCH_CHG_CNT_EN
      chk({tag, ".chg_cnt"}, chg_cnt, 16'(m_cnt));
`endif
   endtask

   // Drive inputs and apply the latch rules: reset wins, st=1 passes d,
   // st=0 keeps whatever was stored.
   task automatic drive(input logic r, input logic s, input logic [W-1:0] dv);
      rst_n = r;
      st    = s;
      d     = dv;
      if (!r) begin
         m_q    = RV;
         m_sync = RV;
         m_chg  = 1'b0;
         m_cnt  = 0;
      end else if (s) begin
         m_q = dv;
      end
   endtask

   // Advance one clock: model the sampled copy at the rising edge, then wait
   // for the falling edge so checks and new stimulus stay away from it.
   task automatic tick();
      @(posedge cl);
      if (rst_n) begin
         if (m_chg && m_cnt < 32'hFFFF) m_cnt++;
         m_chg  = (m_q != m_sync);
         m_sync = m_q;
      end
      @(negedge cl);
   endtask

   initial begin
      // 1: reset with st=1,d=1, then release
      drive(1'b0, 1'b1, 8'h01);
      tick();
      check_all("t1_reset");
      #1 drive(1'b1, 1'b1, 8'h01);
      #1 check_all("t1_release_immediate");
      tick();
      check_all("t1_sync_pulse");
      tick();
      check_all("t1_pulse_end");

      // 2: zero-latency tracking, then hold against a changing d
      #1 drive(1'b1, 1'b1, 8'h00);
      #1 check_all("t2_track0");
      #1 drive(1'b1, 1'b1, 8'h01);
      #1 check_all("t2_track1");
      tick();
      #1 drive(1'b1, 1'b1, 8'h00);
      #1 check_all("t2_track2");
      #1 drive(1'b1, 1'b0, 8'h01);
      #1 check_all("t2_hold_now");
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("t2_hold_cycle");
      end

      // 3: st falls together with a d change -> old d is kept
      #1 drive(1'b1, 1'b1, 8'h01);
      #1 drive(1'b1, 1'b0, 8'h00);
      #1 check_all("t3_simul_edge");
      tick();
      check_all("t3_after_edge");

      // 4: short reset pulse while holding, release with st=0
      tick();
      #1 drive(1'b0, 1'b0, 8'h01);
      #1 check_all("t4_in_reset");
      #1 drive(1'b1, 1'b0, 8'h01);
      #1 check_all("t4_release_hold");
      tick();
      check_all("t4_hold_after");
      #1 drive(1'b1, 1'b1, 8'h01);
      #1 check_all("t4_reopen");
      tick();
      tick();

      // 5: full-width load, hold against new data, then reopen
      #1 drive(1'b1, 1'b1, 8'hA5);
      #1 drive(1'b1, 1'b0, 8'hA5);
      tick();
      tick();
      #1 drive(1'b1, 1'b0, 8'h5A);
      #1 check_all("t5_hold_a5");
      tick();
      check_all("t5_no_chg");
      #1 drive(1'b1, 1'b1, 8'h5A);
      #1 drive(1'b1, 1'b0, 8'h5A);
      #1 check_all("t5_load_5a");
      tick();
      check_all("t5_chg_pulse");
      tick();
      check_all("t5_chg_single");

`ifdef BASIC_D_LATCH_CHG_CNT_EN
      // 6: counter counts changes and saturates
      #1 drive(1'b0, 1'b0, 8'h00);
      #1 drive(1'b1, 1'b0, 8'h00);
      for (int i = 1; i <= 5; i++) begin
         tick();
         #1 drive(1'b1, 1'b1, 8'(i));
         tick();
      end
      tick();
      check_all("t6_five_changes");
      chk("t6_cnt5", chg_cnt, 16'd5);
      force dut.chg_cnt_q = 16'hFFFE;
      m_cnt = 32'hFFFE;
      #1 release dut.chg_cnt_q;
      for (int i = 0; i < 3; i++) begin
         tick();
         #1 drive(1'b1, 1'b1, 8'(8'h40 + i));
         tick();
      end
      tick();
      check_all("t6_saturate");
      chk("t6_cnt_sat", chg_cnt, 16'hFFFF);
`endif

      // Randomized traffic: two input updates per cycle, rare reset pulses.
      for (int i = 0; i < 300; i++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            logic         r;
            logic         s;
            logic [W-1:0] dv;
            r  = ($urandom_range(0, 39) != 0);
            s  = ($urandom_range(0, 2) == 0);
            dv = 8'($urandom);
            #1 drive(r, s, dv);
            #1 check_all("rand");
         end
         if (!rst_n) begin
            drive(1'b1, st, d);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_basic_d_latch
